// File: rtl/seq_ab_responder.sv
// seq_ab_responder: responder for the a/b/c sequence protocol.
// Drives c in the same cycle as a b that ends a qualifying run of a, so that
// "a[*MIN_REP:MAX_REP] ##1 b |-> c" holds. Also provides a registered copy of c,
// a saturating match counter and a sticky overflow flag.
module seq_ab_responder #(
    parameter int unsigned MIN_REP = 1,
    parameter int unsigned MAX_REP = 2,
    parameter int unsigned STRICT  = 0,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             a,
    input  logic             b,
    output logic             c,
    output logic             c_q,
    output logic [CNT_W-1:0] match_cnt,
    output logic             ovf
);

    // Run counter holds 0..MAX_REP+1; MAX_REP+1 means "longer than MAX_REP".
    localparam int unsigned RunW = $clog2(MAX_REP + 2);

    localparam logic [RunW-1:0]  RunMin = RunW'(MIN_REP);
    localparam logic [RunW-1:0]  RunMax = RunW'(MAX_REP);
    localparam logic [RunW-1:0]  RunSat = RunW'(MAX_REP + 1);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    // Bad parameterisations stop elaboration.
    if (MIN_REP < 1) begin : g_chk_min_rep
        $fatal(1, "seq_ab_responder: MIN_REP must be >= 1");
    end
    if (MAX_REP < MIN_REP) begin : g_chk_max_ge_min
        $fatal(1, "seq_ab_responder: MAX_REP must be >= MIN_REP");
    end
    if (MAX_REP > 255) begin : g_chk_max_rep
        $fatal(1, "seq_ab_responder: MAX_REP must be <= 255");
    end
    if (CNT_W < 1) begin : g_chk_cnt_w
        $fatal(1, "seq_ab_responder: CNT_W must be >= 1");
    end

    logic [RunW-1:0]  run_q, run_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic             ovf_q, ovf_d;
    logic             run_ok;

    // Run length of consecutive enabled a cycles, saturating just past MAX_REP.
    always_comb begin
        run_d = '0;
        if (en && a) begin
            run_d = (run_q == RunSat) ? run_q : run_q + RunW'(1);
        end
    end

    // Response: b is judged against the run that ended in the previous cycle.
    always_comb begin
        run_ok = (run_q >= RunMin);
        // In strict mode over-long runs are rejected; otherwise any run >= MIN_REP
        // already contains a suffix of legal length.
        if (STRICT != 0) begin
            run_ok = run_ok && (run_q <= RunMax);
        end
        c = en && b && run_ok;
    end

    // Match counter and sticky overflow; clr wins over a coincident match.
    always_comb begin
        match_cnt_d = match_cnt_q;
        ovf_d       = ovf_q;
        if (clr) begin
            match_cnt_d = '0;
            ovf_d       = 1'b0;
        end else if (c) begin
            if (match_cnt_q == CntMax) begin
                ovf_d = 1'b1;
            end else begin
                match_cnt_d = match_cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers, cleared asynchronously so c drops as soon as reset asserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q       <= '0;
            c_q         <= 1'b0;
            match_cnt_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            run_q       <= run_d;
            c_q         <= c;
            match_cnt_q <= match_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    assign match_cnt = match_cnt_q;
    assign ovf       = ovf_q;

    // Property check. A run of k in [MIN_REP, MAX_REP] a cycles before b exists
    // exactly when the last MIN_REP cycles all had a, so a MIN_REP-deep history of
    // enabled a is enough to express the antecedent. It only feeds the assertions
    // and is dropped by synthesis.
    logic [MIN_REP-1:0] a_hist_q, a_hist_d;

    // Shift in the enabled a of the current cycle.
    always_comb begin
        a_hist_d = MIN_REP'({a_hist_q, (en & a)});
    end

    // History register, cleared with the rest of the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_hist_q <= '0;
        end else begin
            a_hist_q <= a_hist_d;
        end
    end

    // Strict mode deliberately narrows the match set, so completeness only holds
    // for the non-strict responder.
    if (STRICT == 0) begin : g_prop_complete
        a_seq_implies_c: assert property (
            @(posedge clk) disable iff (!rst_n || !en) (b && (&a_hist_q)) |-> c
        ) else $error("seq_ab_responder: qualifying a/b sequence without c");
    end

    a_c_needs_seq: assert property (
        @(posedge clk) disable iff (!rst_n || !en) c |-> (b && (&a_hist_q))
    ) else $error("seq_ab_responder: c without a qualifying a/b sequence");

endmodule

// File: tb/tb_seq_ab_responder.sv
// Bench for seq_ab_responder: three instances (defaults, strict, 2-bit counter)
// share one stimulus stream; expected values come from an a-history model.
module tb_seq_ab_responder;

    logic clk = 1'b0;
    logic rst_n, en, clr, a, b;

    logic       c_def, cq_def, ovf_def;
    logic [7:0] cnt_def;
    logic       c_str, cq_str, ovf_str;
    logic [7:0] cnt_str;
    logic       c_w2, cq_w2, ovf_w2;
    logic [1:0] cnt_w2;

    always #5 clk = ~clk;

    seq_ab_responder u_def (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b),
        .c(c_def), .c_q(cq_def), .match_cnt(cnt_def), .ovf(ovf_def)
    );

    seq_ab_responder #(.STRICT(1)) u_str (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b),
        .c(c_str), .c_q(cq_str), .match_cnt(cnt_str), .ovf(ovf_str)
    );

    seq_ab_responder #(.CNT_W(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b),
        .c(c_w2), .c_q(cq_w2), .match_cnt(cnt_w2), .ovf(ovf_w2)
    );

    typedef struct {
        logic c_def;
        logic c_str;
        logic c_w2;
    } exp_t;

    exp_t sb_q[$];

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // hist[0] is en&a of the previous cycle, hist[1] the one before, ...
    logic [7:0] hist;
    logic       m_cq_def, m_cq_str, m_cq_w2;
    logic [7:0] m_cnt_def, m_cnt_str;
    logic [1:0] m_cnt_w2;
    logic       m_ovf_def, m_ovf_str, m_ovf_w2;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Saturating counter step; returns {ovf, cnt}.
    function automatic logic [8:0] cnt_next(input logic [7:0] cnt, input logic [7:0] max,
                                            input logic ovf_in, input logic hit,
                                            input logic clr_in);
        if (clr_in) return 9'd0;
        if (!hit) return {ovf_in, cnt};
        if (cnt == max) return {1'b1, cnt};
        return {ovf_in, cnt + 8'd1};
    endfunction

    task automatic model_reset();
        hist      = '0;
        m_cq_def  = 1'b0;
        m_cq_str  = 1'b0;
        m_cq_w2   = 1'b0;
        m_cnt_def = '0;
        m_cnt_str = '0;
        m_cnt_w2  = '0;
        m_ovf_def = 1'b0;
        m_ovf_str = 1'b0;
        m_ovf_w2  = 1'b0;
    endtask

    // One clock cycle: drive at posedge+1, compare at negedge, advance model at posedge.
    task automatic step(input logic en_v, input logic clr_v, input logic a_v, input logic b_v);
        exp_t e;
        exp_t p;
        logic [8:0] nx;
        en  = en_v;
        clr = clr_v;
        a   = a_v;
        b   = b_v;
        e.c_def = en_v & b_v & hist[0];
        // Strict: run must be 1 or 2 long, i.e. not three a cycles in a row.
        e.c_str = en_v & b_v & hist[0] & ~(hist[1] & hist[2]);
        e.c_w2  = e.c_def;
        sb_q.push_back(e);
        @(negedge clk);
        p = sb_q.pop_front();
        check_eq("c_def", c_def, p.c_def);
        check_eq("c_str", c_str, p.c_str);
        check_eq("c_w2", c_w2, p.c_w2);
        check_eq("cq_def", cq_def, m_cq_def);
        check_eq("cq_str", cq_str, m_cq_str);
        check_eq("cq_w2", cq_w2, m_cq_w2);
        check_eq("cnt_def", cnt_def, m_cnt_def);
        check_eq("cnt_str", cnt_str, m_cnt_str);
        check_eq("cnt_w2", cnt_w2, m_cnt_w2);
        check_eq("ovf_def", ovf_def, m_ovf_def);
        check_eq("ovf_str", ovf_str, m_ovf_str);
        check_eq("ovf_w2", ovf_w2, m_ovf_w2);
        @(posedge clk);
        m_cq_def = p.c_def;
        m_cq_str = p.c_str;
        m_cq_w2  = p.c_w2;
        nx = cnt_next(m_cnt_def, 8'hff, m_ovf_def, p.c_def, clr_v);
        {m_ovf_def, m_cnt_def} = nx;
        nx = cnt_next(m_cnt_str, 8'hff, m_ovf_str, p.c_str, clr_v);
        {m_ovf_str, m_cnt_str} = nx;
        nx = cnt_next({6'd0, m_cnt_w2}, 8'd3, m_ovf_w2, p.c_w2, clr_v);
        m_ovf_w2 = nx[8];
        m_cnt_w2 = nx[1:0];
        hist = {hist[6:0], en_v & a_v};
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        a     = 1'b0;
        b     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_c", c_def, 0);
        check_eq("rst_cq", cq_def, 0);
        check_eq("rst_cnt", cnt_def, 0);
        check_eq("rst_ovf", ovf_def, 0);
        rst_n = 1'b1;

        // Single a then b: match, c_q follows a cycle later.
        step(1, 0, 1, 0);
        step(1, 0, 0, 1);
        step(1, 0, 0, 0);
        check_eq("tp1_cnt", cnt_def, 1);

        // Three a then b: only the non-strict responder matches.
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        step(1, 0, 0, 1);
        check_eq("tp2_cnt_def", cnt_def, 2);
        check_eq("tp2_cnt_str", cnt_str, 1);

        // Overlapping back-to-back matches.
        step(1, 0, 1, 0);
        step(1, 0, 1, 1);
        step(1, 0, 0, 1);
        check_eq("tp3_cnt_def", cnt_def, 4);
        check_eq("tp3_cnt_w2", cnt_w2, 3);
        check_eq("tp3_ovf_w2", ovf_w2, 1);

        // b without a, then a while disabled followed by b: no match.
        step(1, 0, 0, 1);
        step(0, 0, 1, 0);
        step(1, 0, 0, 1);
        check_eq("tp4_cnt_def", cnt_def, 4);

        // Fifth match keeps the 2-bit counter saturated, then clr beats a match.
        step(1, 0, 1, 0);
        step(1, 0, 0, 1);
        check_eq("tp5_cnt_w2", cnt_w2, 3);
        check_eq("tp5_ovf_w2", ovf_w2, 1);
        step(1, 0, 1, 0);
        step(1, 1, 0, 1);
        check_eq("tp5_clr_cnt_w2", cnt_w2, 0);
        check_eq("tp5_clr_ovf_w2", ovf_w2, 0);
        check_eq("tp5_clr_cnt_def", cnt_def, 0);

        // Build a run and a count, then reset mid-cycle: run must be lost.
        step(1, 0, 1, 0);
        step(1, 0, 1, 1);
        step(1, 0, 1, 0);
        #2;
        rst_n = 1'b0;
        a     = 1'b0;
        b     = 1'b1;
        #1;
        check_eq("rst_mid_c_def", c_def, 0);
        check_eq("rst_mid_c_str", c_str, 0);
        check_eq("rst_mid_cq", cq_def, 0);
        check_eq("rst_mid_cnt", cnt_def, 0);
        check_eq("rst_mid_ovf_w2", ovf_w2, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 0, 0, 1);

        // Random traffic against the history model.
        for (int i = 0; i < 400; i++) begin
            step(logic'($urandom_range(0, 9) != 0), logic'($urandom_range(0, 59) == 0),
                 logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
